// File: rtl/acc_req_arbiter_pkg.sv
// Shared definitions for the ACC request arbiter and its users.
//   idx_width    : bits needed to index num_idx requesters (at least 1)
//   ext_id_width : width of the extended ID, {requester index, requester ID}
//   rsp_kind_e   : classification of the response currently on the shared port
package acc_req_arbiter_pkg;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        if (num_idx > 32'd1) begin
            return 32'($clog2(num_idx));
        end else begin
            return 32'd1;
        end
    endfunction

    function automatic int unsigned ext_id_width(input int unsigned id_width,
                                                 input int unsigned num_req);
        return id_width + idx_width(num_req);
    endfunction

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,   // no response offered
        RSP_ROUTE = 2'd1,   // response addressed to a requester with credit outstanding
        RSP_DROP  = 2'd2    // misrouted or unexpected response, swallowed
    } rsp_kind_e;

endpackage

// File: rtl/acc_req_arbiter_credit_cnt.sv
// Outstanding-request counter for one requester.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   inc_i         : request handshake of this requester
//   dec_i         : response handshake delivered to this requester
//   full_o        : MaxOutstanding requests in flight (registered)
//   empty_o       : no request in flight (registered)
module acc_req_arbiter_credit_cnt #(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0] cnt_r;
    logic [CntWidth-1:0] cnt_nxt_s;
    logic                full_r;
    logic                empty_r;

    // Next count: simultaneous increment and decrement cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (inc_i && !dec_i) begin
            cnt_nxt_s = cnt_r + CntWidth'(1);
        end else if (dec_i && !inc_i) begin
            cnt_nxt_s = cnt_r - CntWidth'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register; the flags are decoded from the next value so they stay registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r   <= {CntWidth{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_nxt_s;
            full_r  <= (cnt_nxt_s == CntMax);
            empty_r <= (cnt_nxt_s == {CntWidth{1'b0}});
        end
    end

    assign full_o  = full_r;
    assign empty_o = empty_r;

endmodule

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator responder port among NumReq requesters.
//   slv_q_* : per-requester request channels (valid/ready/id/payload)
//   slv_p_* : per-requester response valid/ready, broadcast response id/payload
//   mst_q_* : shared request channel, id extended with the winner index on top
//   mst_p_* : shared response channel, id MSBs select the destination requester
//   err_o   : sticky flag, set by a response to an unknown or idle requester
module acc_req_arbiter
    import acc_req_arbiter_pkg::*;
#(
    parameter  int unsigned NumReq          = 4,
    parameter  int unsigned IdWidth         = 1,
    parameter  int unsigned ReqPayloadWidth = 100,
    parameter  int unsigned RspPayloadWidth = 66,
    parameter  int unsigned MaxOutstanding  = 4,
    localparam int unsigned IdxWidth        = idx_width(NumReq),
    localparam int unsigned ExtIdWidth      = ext_id_width(IdWidth, NumReq)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumReq-1:0]                       slv_q_valid_i,
    output logic [NumReq-1:0]                       slv_q_ready_o,
    input  logic [NumReq-1:0][IdWidth-1:0]          slv_q_id_i,
    input  logic [NumReq-1:0][ReqPayloadWidth-1:0]  slv_q_payload_i,
    output logic [NumReq-1:0]                       slv_p_valid_o,
    input  logic [NumReq-1:0]                       slv_p_ready_i,
    output logic [IdWidth-1:0]                      slv_p_id_o,
    output logic [RspPayloadWidth-1:0]              slv_p_payload_o,
    output logic                                    mst_q_valid_o,
    input  logic                                    mst_q_ready_i,
    output logic [ExtIdWidth-1:0]                   mst_q_id_o,
    output logic [ReqPayloadWidth-1:0]              mst_q_payload_o,
    input  logic                                    mst_p_valid_i,
    output logic                                    mst_p_ready_o,
    input  logic [ExtIdWidth-1:0]                   mst_p_id_i,
    input  logic [RspPayloadWidth-1:0]              mst_p_payload_i,
    output logic                                    err_o
);

    logic [IdxWidth-1:0] rr_r;
    logic                lock_r;
    logic [IdxWidth-1:0] lock_idx_r;
    logic                err_r;

    logic [NumReq-1:0]   full_s;
    logic [NumReq-1:0]   empty_s;
    logic [NumReq-1:0]   elig_s;
    logic [NumReq-1:0]   inc_s;
    logic [NumReq-1:0]   dec_s;
    logic                search_found_s;
    logic [IdxWidth-1:0] search_idx_s;
    logic [IdxWidth-1:0] cand_s;
    logic [IdxWidth-1:0] win_idx_s;
    logic [IdxWidth-1:0] rr_nxt_s;
    logic                q_hs_s;
    logic [IdxWidth-1:0] dest_s;
    logic                dest_live_s;
    logic                dest_ready_s;
    rsp_kind_e           rsp_kind_s;

    assign elig_s = slv_q_valid_i & ~full_s;

    // First eligible requester at or after the round-robin pointer, wrapping.
    always_comb begin
        search_found_s = 1'b0;
        search_idx_s   = {IdxWidth{1'b0}};
        cand_s         = {IdxWidth{1'b0}};
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand_s = IdxWidth'((32'(rr_r) + k) % NumReq);
            if (!search_found_s && elig_s[cand_s]) begin
                search_found_s = 1'b1;
                search_idx_s   = cand_s;
            end else begin
                search_found_s = search_found_s;
            end
        end
    end

    // A pending, un-accepted request keeps its winner so valid/payload cannot change under it.
    assign win_idx_s       = lock_r ? lock_idx_r : search_idx_s;
    assign mst_q_valid_o   = search_found_s | lock_r;
    assign q_hs_s          = mst_q_valid_o & mst_q_ready_i;
    assign mst_q_id_o      = {win_idx_s, slv_q_id_i[win_idx_s]};
    assign mst_q_payload_o = slv_q_payload_i[win_idx_s];
    assign rr_nxt_s        = (win_idx_s == IdxWidth'(NumReq - 1)) ? {IdxWidth{1'b0}}
                                                                  : win_idx_s + IdxWidth'(1);

    // Request-side grant: only the winner sees ready, and only it gains a credit.
    always_comb begin
        slv_q_ready_o = {NumReq{1'b0}};
        inc_s         = {NumReq{1'b0}};
        for (int unsigned i = 0; i < NumReq; i++) begin
            slv_q_ready_o[i] = mst_q_valid_o & mst_q_ready_i & (win_idx_s == IdxWidth'(i));
            inc_s[i]         = slv_q_ready_o[i];
        end
    end

    assign dest_s = mst_p_id_i[ExtIdWidth-1:IdWidth];

    // Destination lookup; out-of-range indices match no requester and so read as idle.
    always_comb begin
        dest_live_s  = 1'b0;
        dest_ready_s = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            dest_live_s  = dest_live_s  | ((dest_s == IdxWidth'(i)) & ~empty_s[i]);
            dest_ready_s = dest_ready_s | ((dest_s == IdxWidth'(i)) & slv_p_ready_i[i]);
        end
    end

    // Classify the offered response.
    always_comb begin
        rsp_kind_s = RSP_NONE;
        if (!mst_p_valid_i) begin
            rsp_kind_s = RSP_NONE;
        end else if (dest_live_s) begin
            rsp_kind_s = RSP_ROUTE;
        end else begin
            rsp_kind_s = RSP_DROP;
        end
    end

    // Response demux; unroutable responses are accepted and discarded.
    always_comb begin
        slv_p_valid_o = {NumReq{1'b0}};
        dec_s         = {NumReq{1'b0}};
        mst_p_ready_o = dest_live_s ? dest_ready_s : 1'b1;
        case (rsp_kind_s)
            RSP_ROUTE: begin
                for (int unsigned i = 0; i < NumReq; i++) begin
                    slv_p_valid_o[i] = (dest_s == IdxWidth'(i));
                    dec_s[i]         = slv_p_valid_o[i] & dest_ready_s;
                end
            end
            RSP_DROP: begin
                slv_p_valid_o = {NumReq{1'b0}};
            end
            default: begin
                slv_p_valid_o = {NumReq{1'b0}};
            end
        endcase
    end

    assign slv_p_id_o      = mst_p_id_i[IdWidth-1:0];
    assign slv_p_payload_o = mst_p_payload_i;

    // Round-robin pointer, winner lock and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_r       <= {IdxWidth{1'b0}};
            lock_r     <= 1'b0;
            lock_idx_r <= {IdxWidth{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (q_hs_s) begin
                rr_r   <= rr_nxt_s;
                lock_r <= 1'b0;
            end else if (mst_q_valid_o) begin
                lock_r     <= 1'b1;
                lock_idx_r <= win_idx_s;
            end
            if (rsp_kind_s == RSP_DROP) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err_o = err_r;

    // One credit counter per requester.
    for (genvar g = 0; g < NumReq; g++) begin : g_cnt
        acc_req_arbiter_credit_cnt #(
            .MaxOutstanding(MaxOutstanding)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc_i  (inc_s[g]),
            .dec_i  (dec_s[g]),
            .full_o (full_s[g]),
            .empty_o(empty_s[g])
        );
    end

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter: NumReq=4, IdWidth=1, MaxOutstanding=2.
module tb_acc_req_arbiter;

    logic                clk_i;
    logic                rst_ni;
    logic [3:0]          slv_q_valid_i;
    logic [3:0]          slv_q_ready_o;
    logic [3:0][0:0]     slv_q_id_i;
    logic [3:0][99:0]    slv_q_payload_i;
    logic [3:0]          slv_p_valid_o;
    logic [3:0]          slv_p_ready_i;
    logic [0:0]          slv_p_id_o;
    logic [65:0]         slv_p_payload_o;
    logic                mst_q_valid_o;
    logic                mst_q_ready_i;
    logic [2:0]          mst_q_id_o;
    logic [99:0]         mst_q_payload_o;
    logic                mst_p_valid_i;
    logic                mst_p_ready_o;
    logic [2:0]          mst_p_id_i;
    logic [65:0]         mst_p_payload_i;
    logic                err_o;

    int n_tests = 0;
    int n_fail  = 0;

    acc_req_arbiter #(
        .NumReq(4), .IdWidth(1), .ReqPayloadWidth(100), .RspPayloadWidth(66), .MaxOutstanding(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .slv_q_valid_i(slv_q_valid_i), .slv_q_ready_o(slv_q_ready_o),
        .slv_q_id_i(slv_q_id_i), .slv_q_payload_i(slv_q_payload_i),
        .slv_p_valid_o(slv_p_valid_o), .slv_p_ready_i(slv_p_ready_i),
        .slv_p_id_o(slv_p_id_o), .slv_p_payload_o(slv_p_payload_o),
        .mst_q_valid_o(mst_q_valid_o), .mst_q_ready_i(mst_q_ready_i),
        .mst_q_id_o(mst_q_id_o), .mst_q_payload_o(mst_q_payload_o),
        .mst_p_valid_i(mst_p_valid_i), .mst_p_ready_o(mst_p_ready_o),
        .mst_p_id_i(mst_p_id_i), .mst_p_payload_i(mst_p_payload_i),
        .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [99:0] req_pl(input int i);
        return 100'(64'hC0DE_0000_0000_0000 + 64'(i));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change here, outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        slv_q_valid_i   = 4'b0000;
        mst_q_ready_i   = 1'b0;
        slv_p_ready_i   = 4'b1111;
        mst_p_valid_i   = 1'b0;
        mst_p_id_i      = 3'b000;
        mst_p_payload_i = 66'h0;
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [1:0] w2;
        rst_ni = 1'b1;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            slv_q_id_i[i]      = 1'(i % 2);
            slv_q_payload_i[i] = req_pl(i);
        end

        // Reset state and plain round robin 0,1,2,3,0
        reset_dut();
        #2;
        chk("rst_err", 128'(err_o), 128'(1'b0));
        chk("rst_qvalid", 128'(mst_q_valid_o), 128'(1'b0));
        chk("rst_pvalid", 128'(slv_p_valid_o), 128'(4'b0000));
        slv_q_valid_i = 4'b1111;
        mst_q_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            w2 = 2'(k % 4);
            chk("rr_id", 128'(mst_q_id_o), 128'({w2, w2[0]}));
            chk("rr_ready", 128'(slv_q_ready_o), 128'(4'b0001 << w2));
            chk("rr_payload", 128'(mst_q_payload_o), 128'(req_pl(k % 4)));
            tick();
        end

        // Lock holds winner 2 under backpressure even when 0 arrives
        reset_dut();
        slv_q_valid_i = 4'b0100;
        mst_q_ready_i = 1'b0;
        #2;
        chk("lock_valid", 128'(mst_q_valid_o), 128'(1'b1));
        chk("lock_win0", 128'(mst_q_id_o[2:1]), 128'(2'd2));
        chk("lock_noready", 128'(slv_q_ready_o), 128'(4'b0000));
        tick();
        tick();
        tick();
        slv_q_valid_i = 4'b0101;
        #2;
        chk("lock_win_held", 128'(mst_q_id_o[2:1]), 128'(2'd2));
        chk("lock_payload", 128'(mst_q_payload_o), 128'(req_pl(2)));
        tick();
        mst_q_ready_i = 1'b1;
        #2;
        chk("lock_grant2", 128'(slv_q_ready_o), 128'(4'b0100));
        tick();
        slv_q_valid_i = 4'b0001;
        #2;
        chk("lock_then0", 128'(slv_q_ready_o), 128'(4'b0001));
        chk("lock_then0_id", 128'(mst_q_id_o[2:1]), 128'(2'd0));
        tick();
        idle_inputs();

        // Credit limit on requester 1, then release by a response
        reset_dut();
        slv_q_valid_i = 4'b0010;
        mst_q_ready_i = 1'b1;
        #2;
        chk("cred_g1", 128'(slv_q_ready_o), 128'(4'b0010));
        tick();
        #2;
        chk("cred_g2", 128'(slv_q_ready_o), 128'(4'b0010));
        tick();
        #2;
        chk("cred_skip_rdy", 128'(slv_q_ready_o), 128'(4'b0000));
        chk("cred_skip_vld", 128'(mst_q_valid_o), 128'(1'b0));
        mst_p_valid_i   = 1'b1;
        mst_p_id_i      = {2'd1, 1'b1};
        mst_p_payload_i = 66'h2_1234_5678_9ABC_DEF0;
        slv_p_ready_i   = 4'b1101;
        #2;
        chk("rsp_route", 128'(slv_p_valid_o), 128'(4'b0010));
        chk("rsp_backpr", 128'(mst_p_ready_o), 128'(1'b0));
        tick();
        slv_p_ready_i = 4'b1111;
        #2;
        chk("rsp_ready", 128'(mst_p_ready_o), 128'(1'b1));
        chk("rsp_id", 128'(slv_p_id_o), 128'(1'b1));
        chk("rsp_payload", 128'(slv_p_payload_o), 128'(66'h2_1234_5678_9ABC_DEF0));
        chk("cred_same_cyc", 128'(mst_q_valid_o), 128'(1'b0));
        tick();
        mst_p_valid_i = 1'b0;
        #2;
        chk("cred_regrant", 128'(slv_q_ready_o), 128'(4'b0010));
        tick();
        slv_q_valid_i = 4'b0000;

        // Unexpected response to idle requester 3
        mst_p_valid_i = 1'b1;
        mst_p_id_i    = {2'd3, 1'b0};
        #2;
        chk("drop_ready", 128'(mst_p_ready_o), 128'(1'b1));
        chk("drop_novalid", 128'(slv_p_valid_o), 128'(4'b0000));
        chk("drop_err_pre", 128'(err_o), 128'(1'b0));
        tick();
        mst_p_valid_i = 1'b0;
        #2;
        chk("drop_err", 128'(err_o), 128'(1'b1));
        tick();
        #2;
        chk("drop_err_sticky", 128'(err_o), 128'(1'b1));

        // Same-cycle grant and retire on requester 0 keeps count at 1
        reset_dut();
        slv_q_valid_i = 4'b0001;
        mst_q_ready_i = 1'b1;
        #2;
        chk("both_g1", 128'(slv_q_ready_o), 128'(4'b0001));
        tick();
        mst_p_valid_i = 1'b1;
        mst_p_id_i    = {2'd0, 1'b0};
        #2;
        chk("both_pvalid", 128'(slv_p_valid_o), 128'(4'b0001));
        chk("both_qgrant", 128'(slv_q_ready_o), 128'(4'b0001));
        tick();
        mst_p_valid_i = 1'b0;
        #2;
        chk("both_cnt_lt2", 128'(slv_q_ready_o), 128'(4'b0001));
        tick();
        #2;
        chk("both_cnt_eq2", 128'(mst_q_valid_o), 128'(1'b0));
        idle_inputs();

        // Reset in the middle of a lock with counts at 2 and error set
        reset_dut();
        slv_q_valid_i = 4'b0010;
        mst_q_ready_i = 1'b1;
        tick();
        tick();
        slv_q_valid_i = 4'b0100;
        mst_q_ready_i = 1'b0;
        mst_p_valid_i = 1'b1;
        mst_p_id_i    = {2'd3, 1'b0};
        tick();
        mst_p_valid_i = 1'b0;
        #2;
        chk("mid_err_set", 128'(err_o), 128'(1'b1));
        chk("mid_locked", 128'(mst_q_id_o[2:1]), 128'(2'd2));
        rst_ni = 1'b0;
        tick();
        rst_ni        = 1'b1;
        slv_q_valid_i = 4'b1110;
        #2;
        chk("post_err", 128'(err_o), 128'(1'b0));
        chk("post_valid", 128'(mst_q_valid_o), 128'(1'b1));
        chk("post_win", 128'(mst_q_id_o[2:1]), 128'(2'd1));
        mst_q_ready_i = 1'b1;
        #1;
        chk("post_grant", 128'(slv_q_ready_o), 128'(4'b0010));
        tick();
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
